// File: rtl/gol_pkg.sv
// Shared Game-of-Life definitions: neighbour count, evaluator FSM states, live-count type
// and the row-major neighbour offset table used by the address generator and wrap logic.
package gol_pkg;

    localparam int NEIGHBOURS_CNT = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef logic [3:0] live_cnt_t;

    localparam logic [1:0] OFS_MINUS = 2'd0;
    localparam logic [1:0] OFS_ZERO  = 2'd1;
    localparam logic [1:0] OFS_PLUS  = 2'd2;

    // Neighbours 0..7 run top-left to bottom-right, skipping the centre cell.
    function automatic logic [1:0] nbrColOfs(input int n);
        case (n)
            0, 3, 5: nbrColOfs = OFS_MINUS;
            1, 6:    nbrColOfs = OFS_ZERO;
            default: nbrColOfs = OFS_PLUS;
        endcase
    endfunction

    function automatic logic [1:0] nbrRowOfs(input int n);
        if (n < 3)      nbrRowOfs = OFS_MINUS;
        else if (n < 5) nbrRowOfs = OFS_ZERO;
        else            nbrRowOfs = OFS_PLUS;
    endfunction

endpackage

// File: rtl/get_nbrs_address.sv
// Neighbour address generator for a bounded field: raw +/-1 coordinates of all eight
// neighbours plus a flag telling whether each one lies inside the field.
module get_nbrs_address
    import gol_pkg::*;
#(
    parameter int FIELD_W = 4,
    parameter int FIELD_H = 3,
    localparam int XW = $clog2(FIELD_W),
    localparam int YW = $clog2(FIELD_H)
) (
    input  logic [XW-1:0]                     i_cell_x_adr,
    input  logic [YW-1:0]                     i_cell_y_adr,
    output logic [NEIGHBOURS_CNT-1:0][XW-1:0] o_nbr_x_adr,
    output logic [NEIGHBOURS_CNT-1:0][YW-1:0] o_nbr_y_adr,
    output logic [NEIGHBOURS_CNT-1:0]         o_nbr_rel
);

    localparam logic [XW-1:0] XMAX = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(FIELD_H - 1);

    // Out-of-field coordinates may alias into the field; the relevance flag is authoritative.
    always_comb begin
        o_nbr_x_adr = '0;
        o_nbr_y_adr = '0;
        o_nbr_rel   = '0;
        for (int n = 0; n < NEIGHBOURS_CNT; n++) begin
            case (nbrColOfs(n))
                OFS_MINUS: o_nbr_x_adr[n] = i_cell_x_adr - XW'(1);
                OFS_PLUS:  o_nbr_x_adr[n] = i_cell_x_adr + XW'(1);
                default:   o_nbr_x_adr[n] = i_cell_x_adr;
            endcase
            case (nbrRowOfs(n))
                OFS_MINUS: o_nbr_y_adr[n] = i_cell_y_adr - YW'(1);
                OFS_PLUS:  o_nbr_y_adr[n] = i_cell_y_adr + YW'(1);
                default:   o_nbr_y_adr[n] = i_cell_y_adr;
            endcase
            o_nbr_rel[n] = !((nbrColOfs(n) == OFS_MINUS && i_cell_x_adr == '0)   ||
                             (nbrColOfs(n) == OFS_PLUS  && i_cell_x_adr == XMAX) ||
                             (nbrRowOfs(n) == OFS_MINUS && i_cell_y_adr == '0)   ||
                             (nbrRowOfs(n) == OFS_PLUS  && i_cell_y_adr == YMAX));
        end
    end

endmodule

// File: rtl/nbrs_life_eval.sv
// Evaluates the next-generation state of one cell by reading it and its neighbours from a
// 1-cycle-latency cell memory. Define NBRS_TORUS_EN for a wrap-around (toroidal) field.
module nbrs_life_eval
    import gol_pkg::*;
#(
    parameter int FIELD_W = 4,
    parameter int FIELD_H = 3,
    localparam int XW = $clog2(FIELD_W),
    localparam int YW = $clog2(FIELD_H)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [XW-1:0]   i_cell_x_adr,
    input  logic [YW-1:0]   i_cell_y_adr,
    output logic            o_busy,
    output logic            o_rd_en,
    output logic [XW-1:0]   o_rd_x_adr,
    output logic [YW-1:0]   o_rd_y_adr,
    input  logic            i_rd_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_next_alive,
    output logic [3:0]      o_live_cnt
);

    state_t    r_state;
    state_t    w_nextState;
    logic [XW-1:0] r_cellX;
    logic [YW-1:0] r_cellY;
    logic [3:0] r_idx;
    logic [3:0] w_nextIdx;
    logic       w_found;
    logic       r_pend;
    logic       r_pendSelf;
    logic       r_self;
    live_cnt_t  r_cnt;
    logic       w_rdEn;
    logic [2:0] w_sel;

    logic [NEIGHBOURS_CNT-1:0][XW-1:0] w_nbrX;
    logic [NEIGHBOURS_CNT-1:0][YW-1:0] w_nbrY;
    logic [NEIGHBOURS_CNT-1:0]         w_nbrRel;
    logic [NEIGHBOURS_CNT-1:0][XW-1:0] w_rdX;
    logic [NEIGHBOURS_CNT-1:0][YW-1:0] w_rdY;
    logic [NEIGHBOURS_CNT-1:0]         w_rel;

    get_nbrs_address #(
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H)
    ) u_getNbrs (
        .i_cell_x_adr (r_cellX),
        .i_cell_y_adr (r_cellY),
        .o_nbr_x_adr  (w_nbrX),
        .o_nbr_y_adr  (w_nbrY),
        .o_nbr_rel    (w_nbrRel)
    );

`ifdef NBRS_TORUS_EN
    localparam logic [XW-1:0] XMAX = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(FIELD_H - 1);
    logic [XW-1:0] w_xm1;
    logic [XW-1:0] w_xp1;
    logic [YW-1:0] w_ym1;
    logic [YW-1:0] w_yp1;

    // Edge-crossing neighbours wrap explicitly so non-power-of-two sizes stay in the field.
    always_comb begin
        w_xm1 = (r_cellX == '0)   ? XMAX : r_cellX - XW'(1);
        w_xp1 = (r_cellX == XMAX) ? '0   : r_cellX + XW'(1);
        w_ym1 = (r_cellY == '0)   ? YMAX : r_cellY - YW'(1);
        w_yp1 = (r_cellY == YMAX) ? '0   : r_cellY + YW'(1);
        w_rel = '1;
        w_rdX = w_nbrX;
        w_rdY = w_nbrY;
        for (int n = 0; n < NEIGHBOURS_CNT; n++) begin
            if (!w_nbrRel[n]) begin
                case (nbrColOfs(n))
                    OFS_MINUS: w_rdX[n] = w_xm1;
                    OFS_PLUS:  w_rdX[n] = w_xp1;
                    default:   w_rdX[n] = r_cellX;
                endcase
                case (nbrRowOfs(n))
                    OFS_MINUS: w_rdY[n] = w_ym1;
                    OFS_PLUS:  w_rdY[n] = w_yp1;
                    default:   w_rdY[n] = r_cellY;
                endcase
            end
        end
    end
`else
    assign w_rel = w_nbrRel;
    assign w_rdX = w_nbrX;
    assign w_rdY = w_nbrY;
`endif

    // r_idx 0 is the cell itself, 1..8 map to neighbours 0..7; skip to the next relevant one.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_found     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = READ;
                    w_nextIdx   = '0;
                end
            end
            READ: begin
                for (int i = 1; i <= NEIGHBOURS_CNT; i++) begin
                    if (!w_found && 4'(i) > r_idx && w_rel[i-1]) begin
                        w_found   = 1'b1;
                        w_nextIdx = 4'(i);
                    end
                end
                if (!w_found) w_nextState = DRAIN;
            end
            DRAIN:   w_nextState = DONE;
            DONE:    if (i_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_rdEn     = (r_state == READ);
        w_sel      = 3'(r_idx - 4'd1);
        o_rd_x_adr = '0;
        o_rd_y_adr = '0;
        if (w_rdEn) begin
            if (r_idx == '0) begin
                o_rd_x_adr = r_cellX;
                o_rd_y_adr = r_cellY;
            end else begin
                o_rd_x_adr = w_rdX[w_sel];
                o_rd_y_adr = w_rdY[w_sel];
            end
        end
    end

    assign o_rd_en      = w_rdEn;
    assign o_busy       = (r_state != IDLE);
    assign o_valid      = (r_state == DONE);
    assign o_live_cnt   = r_cnt;
    assign o_next_alive = (r_cnt == 4'd3) | (r_self & (r_cnt == 4'd2));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_nextIdx;
        end
    end

    // Read data lands one cycle after its strobe, so remember what each pending read was for.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cellX    <= '0;
            r_cellY    <= '0;
            r_pend     <= 1'b0;
            r_pendSelf <= 1'b0;
            r_self     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_pend     <= w_rdEn;
            r_pendSelf <= w_rdEn && (r_idx == '0);
            if (r_state == IDLE && i_start) begin
                r_cellX <= i_cell_x_adr;
                r_cellY <= i_cell_y_adr;
                r_self  <= 1'b0;
                r_cnt   <= '0;
            end else if (r_pend) begin
                if (r_pendSelf) r_self <= i_rd_data;
                else            r_cnt  <= r_cnt + live_cnt_t'(i_rd_data);
            end
        end
    end

endmodule

// File: tb/tb_nbrs_life_eval.sv
// Scoreboard bench for nbrs_life_eval on a 4x3 field with a 1-cycle-latency cell memory.
// Directed cases; the toroidal case replaces the edge cases when NBRS_TORUS_EN is defined.
module tb_nbrs_life_eval;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       iStart = 1'b0;
    logic       iReady = 1'b1;
    logic [1:0] cellX = '0;
    logic [1:0] cellY = '0;
    logic       rdData = 1'b0;
    logic       oBusy;
    logic       rdEn;
    logic [1:0] rdX;
    logic [1:0] rdY;
    logic       oValid;
    logic       oAlive;
    logic [3:0] oCnt;

    logic mem [0:2][0:3];

    typedef struct {
        int cnt;
        int alive;
        int validCyc;
    } exp_t;

    exp_t resQ[$];
    int   rdExpQ[$];
    exp_t resE;
    int   rdE;
    int   cyc = 0;
    int   nVec = 0;
    int   nFail = 0;
    bit   ignoreReads = 1'b0;
    bit   seenValid = 1'b0;

    nbrs_life_eval #(
        .FIELD_W (4),
        .FIELD_H (3)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_start      (iStart),
        .i_cell_x_adr (cellX),
        .i_cell_y_adr (cellY),
        .o_busy       (oBusy),
        .o_rd_en      (rdEn),
        .o_rd_x_adr   (rdX),
        .o_rd_y_adr   (rdY),
        .i_rd_data    (rdData),
        .o_valid      (oValid),
        .i_ready      (iReady),
        .o_next_alive (oAlive),
        .o_live_cnt   (oCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rdData <= (rdEn && int'(rdY) < 3) ? mem[rdY][rdX] : 1'b0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nVec++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: checks every read strobe against the expected address list and pops a
    // result from the scoreboard on each rising o_valid.
    always @(negedge clk) begin
        if (rdEn) begin
            checkOutput("rdInField", 16'(int'(rdY) < 3), 16'd1);
            if (!ignoreReads) begin
                if (rdExpQ.size() == 0) begin
                    checkOutput("extraRead", 16'(int'(rdX) * 8 + int'(rdY)), 16'hFFFF);
                end else begin
                    rdE = rdExpQ.pop_front();
                    checkOutput("rdAddr", 16'(int'(rdX) * 8 + int'(rdY)), 16'(rdE));
                end
            end
        end
        if (oValid && !seenValid) begin
            if (resQ.size() == 0) begin
                checkOutput("unexpectedValid", 16'(oValid), 16'd0);
            end else begin
                resE = resQ.pop_front();
                checkOutput("liveCnt", 16'(oCnt), 16'(resE.cnt));
                checkOutput("nextAlive", 16'(oAlive), 16'(resE.alive));
                checkOutput("validCycle", 16'(cyc), 16'(resE.validCyc));
                checkOutput("readsMissing", 16'(rdExpQ.size()), 16'd0);
            end
        end
        seenValid = oValid;
    end

    task automatic clearMem(input logic v);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                mem[y][x] = v;
    endtask

    task automatic expectRead(input int x, input int y);
        rdExpQ.push_back(x * 8 + y);
    endtask

    task automatic expectInteriorReads();
        expectRead(1, 1);
        expectRead(0, 0); expectRead(1, 0); expectRead(2, 0);
        expectRead(0, 1); expectRead(2, 1);
        expectRead(0, 2); expectRead(1, 2); expectRead(2, 2);
    endtask

    // Caller sits on a falling edge with the DUT idle; the start is sampled on the next rising edge.
    task automatic applyStimulus(input int x, input int y, input int cnt, input int alive, input int k);
        checkOutput("idleBeforeStart", 16'(oBusy), 16'd0);
        cellX  = 2'(x);
        cellY  = 2'(y);
        iStart = 1'b1;
        resQ.push_back('{cnt, alive, cyc + k + 2});
        @(posedge clk);
        #1 iStart = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while ((oBusy || oValid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleTimeout", 16'(oBusy | oValid), 16'd0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "Busy"},  16'(oBusy),  16'd0);
        checkOutput({name, "RdEn"},  16'(rdEn),   16'd0);
        checkOutput({name, "RdX"},   16'(rdX),    16'd0);
        checkOutput({name, "RdY"},   16'(rdY),    16'd0);
        checkOutput({name, "Valid"}, 16'(oValid), 16'd0);
        checkOutput({name, "Alive"}, 16'(oAlive), 16'd0);
        checkOutput({name, "Cnt"},   16'(oCnt),   16'd0);
    endtask

    task automatic setInteriorMem();
        clearMem(1'b0);
        mem[0][0] = 1'b1;
        mem[0][1] = 1'b1;
        mem[0][2] = 1'b1;
    endtask

    initial begin
        int n;
        int t0;
        clearMem(1'b0);
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;

        // Interior cell, three live cells on the row above: birth.
        setInteriorMem();
        expectInteriorReads();
        applyStimulus(1, 1, 3, 1, 9);
        waitIdle();

`ifdef NBRS_TORUS_EN
        // Corner on a torus: every neighbour wraps into the field.
        clearMem(1'b1);
        expectRead(0, 0);
        expectRead(3, 2); expectRead(0, 2); expectRead(1, 2);
        expectRead(3, 0); expectRead(1, 0);
        expectRead(3, 1); expectRead(0, 1); expectRead(1, 1);
        applyStimulus(0, 0, 8, 0, 9);
        waitIdle();
`else
        // Top-left corner: only three neighbours exist.
        clearMem(1'b0);
        mem[0][0] = 1'b1;
        mem[0][1] = 1'b1;
        expectRead(0, 0); expectRead(1, 0); expectRead(0, 1); expectRead(1, 1);
        applyStimulus(0, 0, 1, 0, 4);
        waitIdle();

        // Bottom-right corner: survival with two neighbours.
        clearMem(1'b0);
        mem[2][3] = 1'b1;
        mem[1][2] = 1'b1;
        mem[1][3] = 1'b1;
        expectRead(3, 2); expectRead(2, 1); expectRead(3, 1); expectRead(2, 2);
        applyStimulus(3, 2, 2, 1, 4);
        waitIdle();
`endif

        // Back-pressure: hold the result for five cycles while a start is pulsed.
        clearMem(1'b0);
        mem[1][1] = 1'b1;
        mem[1][0] = 1'b1;
        mem[1][2] = 1'b1;
        iReady = 1'b0;
        expectInteriorReads();
        applyStimulus(1, 1, 2, 1, 9);
        @(negedge clk);
        n = 0;
        while (!oValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("validTimeout", 16'(oValid), 16'd1);
        for (int c = 0; c < 5; c++) begin
            checkOutput("holdValid", 16'(oValid), 16'd1);
            checkOutput("holdBusy",  16'(oBusy),  16'd1);
            checkOutput("holdCnt",   16'(oCnt),   16'd2);
            checkOutput("holdAlive", 16'(oAlive), 16'd1);
            if (c == 1) begin
                cellX  = 2'd0;
                cellY  = 2'd0;
                iStart = 1'b1;
            end else begin
                iStart = 1'b0;
            end
            @(negedge clk);
        end
        iReady = 1'b1;
        @(negedge clk);
        checkOutput("afterXferValid", 16'(oValid), 16'd0);
        checkOutput("afterXferBusy",  16'(oBusy),  16'd0);

        // Reset in the fourth READ cycle, then restart straight after release.
        setInteriorMem();
        ignoreReads = 1'b1;
        cellX  = 2'd1;
        cellY  = 2'd1;
        iStart = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 iStart = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("read4Cycle", 16'(cyc - t0), 16'd4);
        checkOutput("read4En",    16'(rdEn), 16'd1);
        checkOutput("read4Addr",  16'(int'(rdX) * 8 + int'(rdY)), 16'(2 * 8 + 0));
        rstN = 1'b0;
        #1;
        checkAllZero("midRst");
        ignoreReads = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("inRstBusy", 16'(oBusy), 16'd0);
        checkOutput("inRstRdEn", 16'(rdEn),  16'd0);
        @(negedge clk);
        rstN = 1'b1;
        expectInteriorReads();
        applyStimulus(1, 1, 3, 1, 9);
        waitIdle();

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", 16'(resQ.size()), 16'd0);
        checkOutput("readsDrained", 16'(rdExpQ.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
